sevenseg_scan_n: RTL and testbench

Parametrised, time-multiplexed seven-segment driver for N common-anode digits. Accepts packed hex nibbles, per-digit decimal points and blank masks. Adds frame-coherent input snapshotting, leading-zero suppression, per-slot ghosting dead time and PWM brightness control. Sits between score/debug logic and the board's `seg`/`an` pins.

---
 rtl/sevenseg_scan_n_pkg.sv | 54 +++++
 rtl/sevenseg_scan_n_if.sv | 27 ++
 rtl/sevenseg_decode.sv | 18 +
 rtl/sevenseg_scan_n.sv | 111 +++++++++++
 tb/tb_sevenseg_scan_n.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/sevenseg_scan_n_pkg.sv
// sevenseg_pkg: shared constants and helpers for the seven-segment scanner.
//   SEG_BLANK     : all segments off (active-low pattern).
//   LZ_MAX_DIGITS : widest digit count the leading-zero helper supports.
//   hex_to_seg    : nibble -> active-low {g,f,e,d,c,b,a}.
//   lz_mask       : leading-zero suppression mask for the first n digits.
package sevenseg_pkg;

  localparam logic [7:0] SEG_BLANK     = 8'hFF;
  localparam int         LZ_MAX_DIGITS = 32;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h27;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Walk from the most significant used digit downwards; a digit is
  // suppressed while it and everything above it are zero. Digit 0 always
  // stays visible so a value of zero still shows "0".
  function automatic logic [LZ_MAX_DIGITS-1:0] lz_mask(
    input logic [4*LZ_MAX_DIGITS-1:0] nibs,
    input int                         n
  );
    logic [LZ_MAX_DIGITS-1:0] m;
    logic                     all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int i = LZ_MAX_DIGITS - 1; i >= 1; i--) begin
      if (i < n) begin
        if (nibs[4*i +: 4] != 4'h0) all_zero = 1'b0;
        m[i] = all_zero;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/sevenseg_scan_n_if.sv
// sevenseg_scan_n_if: display-side bundle between the value producer and the
// scanner.
//   master : producer; drives digits/dp/blank/lz_suppress/brightness, sees pins.
//   slave  : scanner; consumes the display request, drives seg/an/frame_start.
interface sevenseg_scan_n_if #(
  parameter int NUM_DIGITS = 4,
  parameter int PWM_BITS   = 4
);
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    lz_suppress;
  logic [PWM_BITS-1:0]     brightness;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_start;

  modport master (
    output digits, dp, blank, lz_suppress, brightness,
    input  seg, an, frame_start
  );

  modport slave (
    input  digits, dp, blank, lz_suppress, brightness,
    output seg, an, frame_start
  );
endinterface

// File: rtl/sevenseg_decode.sv
// sevenseg_decode: combinational segment pattern for one digit.
//   nibble_i : hex value to show
//   dp_i     : decimal point on (active-high)
//   en_i     : digit is lit this cycle; when low the pattern is all dark
//   seg_o    : active-low {dp,g,f,e,d,c,b,a}
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_i,
  input  logic       en_i,
  output logic [7:0] seg_o
);
  always_comb begin
    seg_o = SEG_BLANK;
    if (en_i) seg_o = {~dp_i, hex_to_seg(nibble_i)};
  end
endmodule

// File: rtl/sevenseg_scan_n.sv
// sevenseg_scan_n: time-multiplexed driver for NUM_DIGITS common-anode digits
// with frame snapshot, leading-zero suppression, dead cycle and PWM dimming.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of sevenseg_scan_n_if (request in, seg/an/frame_start out)
// NUM_DIGITS must not exceed sevenseg_pkg::LZ_MAX_DIGITS.
module sevenseg_scan_n
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 25000,
  parameter int PWM_BITS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  sevenseg_scan_n_if.slave  bus
);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST   = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]           p_q, p_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [PWM_BITS-1:0]     pw_q;
  logic [4*NUM_DIGITS-1:0] digits_snap_q;
  logic [NUM_DIGITS-1:0]   dp_snap_q, blank_snap_q;
  logic                    lz_snap_q;
  logic [PWM_BITS-1:0]     bright_snap_q;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    fs_q;

  logic                       snap_cycle;
  logic [4*LZ_MAX_DIGITS-1:0] nibs_ext;
  logic [LZ_MAX_DIGITS-1:0]   lz_full;
  logic [LZ_MAX_DIGITS-1:0]   blank_pad;
  logic [LZ_MAX_DIGITS-1:0]   blank_eff;
  logic                       an_on;
  logic [3:0]                 cur_nib;

  assign snap_cycle = (p_q == '0) && (idx_q == '0);

  always_comb begin
    p_d   = (p_q == P_LAST) ? '0 : p_q + 1'b1;
    idx_d = idx_q;
    if (p_q == P_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  end

  // Leading-zero and blank masks are padded to the helper's fixed width;
  // the padding stays zero and is never selected by idx_q.
  always_comb begin
    nibs_ext                   = '0;
    nibs_ext[4*NUM_DIGITS-1:0] = digits_snap_q;
    lz_full                    = lz_mask(nibs_ext, NUM_DIGITS);
    blank_pad                  = '0;
    blank_pad[NUM_DIGITS-1:0]  = blank_snap_q;
    blank_eff                  = blank_pad | (lz_snap_q ? lz_full : '0);
  end

  // p==0 is a dark cycle in every slot so the previous digit's segments
  // never ghost onto the newly selected anode.
  assign an_on   = (p_q != '0) && (pw_q <= bright_snap_q) && !blank_eff[idx_q];
  assign cur_nib = digits_snap_q[4*idx_q +: 4];

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
      assign an_d[gi] = !(an_on && (idx_q == IW'(gi)));
    end
  endgenerate

  sevenseg_decode u_decode (
    .nibble_i (cur_nib),
    .dp_i     (dp_snap_q[idx_q]),
    .en_i     (an_on),
    .seg_o    (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q           <= '0;
      idx_q         <= '0;
      pw_q          <= '0;
      digits_snap_q <= '0;
      dp_snap_q     <= '0;
      blank_snap_q  <= '0;
      lz_snap_q     <= 1'b0;
      bright_snap_q <= '0;
      seg_q         <= SEG_BLANK;
      an_q          <= '1;
      fs_q          <= 1'b0;
    end else begin
      p_q   <= p_d;
      idx_q <= idx_d;
      pw_q  <= pw_q + 1'b1;
      if (snap_cycle) begin
        digits_snap_q <= bus.digits;
        dp_snap_q     <= bus.dp;
        blank_snap_q  <= bus.blank;
        lz_snap_q     <= bus.lz_suppress;
        bright_snap_q <= bus.brightness;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
      fs_q  <= snap_cycle;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.an          = an_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_sevenseg_scan_n.sv
module tb_sevenseg_scan_n;
  localparam int ND = 4;
  localparam int DV = 4;
  localparam int PB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sevenseg_scan_n_if #(.NUM_DIGITS(ND), .PWM_BITS(PB)) bus ();

  sevenseg_scan_n #(.NUM_DIGITS(ND), .DIV(DV), .PWM_BITS(PB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_fs(input string name, input int budget);
    int  n;
    bit  got;
    n   = 0;
    got = 0;
    while (!got && n < budget) begin
      step();
      n++;
      if (bus.frame_start === 1'b1) got = 1;
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("FAIL %s.frame_start_wait observed=none_in_%0d expected=pulse", name, budget);
    end
  endtask

  // One full frame of 16 samples. Sample s shows the state of slot idx=s/4,
  // p=s%4. With DIV=4 and PWM_BITS=2 both counters reset together, so pw
  // always equals p and a cycle is lit when p!=0 && p<=brightness.
  // segs packs the hand-decoded pattern per digit as {d3,d2,d1,d0};
  // off marks digits that must stay dark (blank or suppressed).
  task automatic check_frame(input string name, input logic [31:0] segs,
                             input logic [3:0] off, input int bright,
                             input int budget, input int chg_s,
                             input logic [15:0] chg_val);
    int         p;
    int         ix;
    bit         on;
    logic [3:0] an_e;
    logic [7:0] seg_e;
    wait_fs(name, budget);
    for (int s = 0; s < 16; s++) begin
      if (s > 0) step();
      p     = s % 4;
      ix    = s / 4;
      on    = (p != 0) && (p <= bright) && !off[ix];
      an_e  = on ? ~(4'b0001 << ix) : 4'hF;
      seg_e = on ? segs[8*ix +: 8] : 8'hFF;
      chk($sformatf("%s.an[%0d]", name, s), {4'h0, bus.an}, {4'h0, an_e});
      chk($sformatf("%s.seg[%0d]", name, s), bus.seg, seg_e);
      chk($sformatf("%s.fs[%0d]", name, s), {7'h0, bus.frame_start}, {7'h0, (s == 0)});
      if (s == chg_s) bus.digits = chg_val;
    end
    $display("frame %s: segs=%h off=%b brightness=%0d checked", name, segs, off, bright);
  endtask

  initial begin
    bus.digits      = 16'h1234;
    bus.dp          = 4'b0000;
    bus.blank       = 4'b0000;
    bus.lz_suppress = 1'b0;
    bus.brightness  = 2'd3;

    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset.seg[%0d]", i), bus.seg, 8'hFF);
      chk($sformatf("reset.an[%0d]", i), {4'h0, bus.an}, 8'h0F);
      chk($sformatf("reset.fs[%0d]", i), {7'h0, bus.frame_start}, 8'h00);
    end
    $display("reset: 3 cycles checked");
    rst = 1'b0;

    // 1234: d0=4->99, d1=3->B0, d2=2->A4, d3=1->F9
    check_frame("h1234_a", 32'hF9A4B099, 4'b0000, 3, 2, -1, 16'h0);
    check_frame("h1234_b", 32'hF9A4B099, 4'b0000, 3, 1, -1, 16'h0);

    bus.digits      = 16'h0050;
    bus.lz_suppress = 1'b1;
    check_frame("lz_0050", 32'hFFFF92C0, 4'b1100, 3, 20, -1, 16'h0);

    bus.digits = 16'h0000;
    check_frame("lz_0000", 32'hFFFFFFC0, 4'b1110, 3, 20, -1, 16'h0);

    bus.digits      = 16'h0030;
    bus.lz_suppress = 1'b0;
    bus.dp          = 4'b0010;
    check_frame("dp_0030", 32'hC0C030C0, 4'b0000, 3, 20, -1, 16'h0);

    bus.blank = 4'b0001;
    check_frame("blank0", 32'hC0C030C0, 4'b0001, 3, 20, -1, 16'h0);

    bus.digits     = 16'h1234;
    bus.dp         = 4'b0000;
    bus.blank      = 4'b0000;
    bus.brightness = 2'd1;
    check_frame("bright1", 32'hF9A4B099, 4'b0000, 1, 20, -1, 16'h0);

    bus.brightness = 2'd0;
    check_frame("bright0", 32'hF9A4B099, 4'b0000, 0, 20, -1, 16'h0);

    // Change digits while slot 2 is being shown; the frame must not tear.
    bus.brightness = 2'd3;
    check_frame("tear_old", 32'hF9A4B099, 4'b0000, 3, 20, 8, 16'h5678);
    // 5678: d0=8->80, d1=7->F8, d2=6->82, d3=5->92
    check_frame("tear_new", 32'h9282F880, 4'b0000, 3, 20, -1, 16'h0);

    // Reset during slot 2, p=2: sample 9 is state idx=2,p=1, so the
    // current cycle is idx=2,p=2.
    wait_fs("pre_rst", 20);
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    chk("midrst.seg", bus.seg, 8'hFF);
    chk("midrst.an", {4'h0, bus.an}, 8'h0F);
    chk("midrst.fs", {7'h0, bus.frame_start}, 8'h00);
    $display("mid-frame reset: checked");
    rst = 1'b0;
    check_frame("after_rst", 32'h9282F880, 4'b0000, 3, 1, -1, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
